dcache_mem_responder: RTL and testbench



---
 rtl/dcache_mem_responder.sv | 125 ++++++++++++
 tb/tb_dcache_mem_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_mem_responder.sv
// dcache_mem_responder
// Target end of the dcache mem_* port: accepts single-word writes and
// answers read requests with a fixed-length burst from an internal array.
// The burst length is advertised on mem_burstlen. Requests that arrive while
// a burst is in flight are dropped and flagged on the sticky mem_err.

module dcache_mem_responder #(
    parameter int DATABITS    = 32,
    parameter int ADDRBITS    = 32,
    parameter int MEMADDRBITS = 10,
    parameter int BURSTLEN    = 32,
    parameter int READLATENCY = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDRBITS-1:0] mem_addr,
    input  logic [DATABITS-1:0] mem_in,
    input  logic                mem_wrreq,
    input  logic                mem_rdreq,
    output logic [DATABITS-1:0] mem_out,
    output logic                mem_out_valid,
    output logic [15:0]         mem_burstlen,
    output logic                mem_busy,
    output logic                mem_err
);

    localparam int DEPTH = 1 << MEMADDRBITS;

    // Latency and burst counters are 16 bits wide, matching the legal
    // range of BURSTLEN advertised on mem_burstlen.
    localparam logic [15:0] LAT_INIT  = 16'(READLATENCY);
    localparam logic [15:0] LAST_BEAT = 16'(BURSTLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAT,
        S_BURST
    } state_t;

    state_t                 state;
    logic [DATABITS-1:0]    mem [DEPTH];
    logic [MEMADDRBITS-1:0] idx;
    logic [MEMADDRBITS-1:0] rd_idx;
    logic [15:0]            cnt_lat;
    logic [15:0]            cnt_burst;
    logic                   wr_en;
    logic                   req_any;
    logic                   unused_addr_bits;

    // Word index from the byte address; byte-lane and upper bits alias.
    assign idx              = mem_addr[MEMADDRBITS+1:2];
    assign unused_addr_bits = ^{mem_addr[ADDRBITS-1:MEMADDRBITS+2], mem_addr[1:0]};

    // Writes are only honoured while idle and out of reset.
    assign wr_en   = reset_n && (state == S_IDLE) && mem_wrreq;
    assign req_any = mem_rdreq | mem_wrreq;

    // Burst length is a pure constant, valid even while reset is held.
    assign mem_burstlen = 16'(BURSTLEN);

    // Backing store write port.
    // NOTE: the array has no reset on purpose - contents survive reset, and a
    // reset branch here would turn a RAM into thousands of flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= mem_in;
        end
    end

    // Request acceptance, latency countdown and burst sequencing.
    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would create ordering-dependent logic.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            rd_idx        <= '0;
            cnt_lat       <= '0;
            cnt_burst     <= '0;
            mem_out       <= '0;
            mem_out_valid <= 1'b0;
            mem_busy      <= 1'b0;
            mem_err       <= 1'b0;
        end else begin
            mem_out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_rdreq) begin
                        // A simultaneous write lands this edge, so the burst
                        // naturally returns the freshly written word first.
                        rd_idx    <= idx;
                        cnt_lat   <= LAT_INIT;
                        cnt_burst <= '0;
                        mem_busy  <= 1'b1;
                        state     <= (READLATENCY == 0) ? S_BURST : S_LAT;
                    end
                end
                S_LAT: begin
                    mem_err <= mem_err | req_any;
                    cnt_lat <= cnt_lat - 16'd1;
                    if (cnt_lat == 16'd1) begin
                        state <= S_BURST;
                    end
                end
                S_BURST: begin
                    mem_err       <= mem_err | req_any;
                    mem_out       <= mem[rd_idx];
                    mem_out_valid <= 1'b1;
                    rd_idx        <= rd_idx + 1'b1;
                    cnt_burst     <= cnt_burst + 16'd1;
                    // Busy drops with the last word so a new request can be
                    // taken during the final valid cycle.
                    if (cnt_burst == LAST_BEAT) begin
                        state    <= S_IDLE;
                        mem_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    mem_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Testbench for dcache_mem_responder: directed stimulus, expected burst words
// pushed to a queue on request, popped and compared by a negedge monitor.

module tb_dcache_mem_responder;

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    // Main DUT: READLATENCY=2, BURSTLEN=32
    logic [31:0] mem_addr, mem_in, mem_out;
    logic        mem_wrreq, mem_rdreq, mem_out_valid, mem_busy, mem_err;
    logic [15:0] mem_burstlen;

    // Corner DUT: READLATENCY=0, BURSTLEN=1
    logic [31:0] addr1, in1, out1;
    logic        wrreq1, rdreq1, valid1, busy1, err1;
    logic [15:0] burstlen1;

    logic [31:0] model [1024];
    exp_t        exp_q [$];

    dcache_mem_responder #(
        .DATABITS(32), .ADDRBITS(32), .MEMADDRBITS(10),
        .BURSTLEN(32), .READLATENCY(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_in(mem_in),
        .mem_wrreq(mem_wrreq), .mem_rdreq(mem_rdreq), .mem_out(mem_out),
        .mem_out_valid(mem_out_valid), .mem_burstlen(mem_burstlen),
        .mem_busy(mem_busy), .mem_err(mem_err)
    );

    dcache_mem_responder #(
        .DATABITS(32), .ADDRBITS(32), .MEMADDRBITS(10),
        .BURSTLEN(1), .READLATENCY(0)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .mem_addr(addr1), .mem_in(in1),
        .mem_wrreq(wrreq1), .mem_rdreq(rdreq1), .mem_out(out1),
        .mem_out_valid(valid1), .mem_burstlen(burstlen1),
        .mem_busy(busy1), .mem_err(err1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time (got timeout, want finish)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every valid word must match the head of the expectation queue,
    // including the cycle it appears in.
    always @(negedge clk) begin
        if (mem_out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("burst_data", mem_out, e.data);
                check("burst_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_to_cycle(input int unsigned n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        mem_addr  = addr;
        mem_in    = data;
        mem_wrreq = 1'b1;
        model[addr[11:2]] = data;
        @(negedge clk);
        mem_wrreq = 1'b0;
    endtask

    // Issue a read (optionally with a simultaneous write); returns the edge
    // number at which the request is sampled. Called at a negedge.
    task automatic do_read(input logic [31:0] addr, input bit with_wr,
                           input logic [31:0] data, output int unsigned e0);
        logic [9:0] start;
        start     = addr[11:2];
        mem_addr  = addr;
        mem_rdreq = 1'b1;
        if (with_wr) begin
            mem_in    = data;
            mem_wrreq = 1'b1;
            model[start] = data;
        end
        e0 = cyc + 1;
        for (int j = 0; j < 32; j++) begin
            exp_t e;
            e.cyc  = e0 + 3 + j;
            e.data = model[10'(start + 10'(j))];
            exp_q.push_back(e);
        end
        @(negedge clk);
        mem_rdreq = 1'b0;
        mem_wrreq = 1'b0;
        check("busy_after_req", mem_busy, 1'b1);
    endtask

    task automatic check_end(input int unsigned e0);
        wait_to_cycle(e0 + 33);
        check("busy_before_last", mem_busy, 1'b1);
        wait_to_cycle(e0 + 34);
        check("busy_at_last", mem_busy, 1'b0);
        check("valid_at_last", mem_out_valid, 1'b1);
        wait_to_cycle(e0 + 35);
        check("valid_after_last", mem_out_valid, 1'b0);
    endtask

    initial begin
        int unsigned e0;
        int unsigned e1;
        int unsigned cut;

        reset_n = 1'b0;
        mem_addr = '0; mem_in = '0; mem_wrreq = 1'b0; mem_rdreq = 1'b0;
        addr1 = '0; in1 = '0; wrreq1 = 1'b0; rdreq1 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values, burst length visible during reset
        check("rst_out", mem_out, 32'h0);
        check("rst_valid", mem_out_valid, 1'b0);
        check("rst_busy", mem_busy, 1'b0);
        check("rst_err", mem_err, 1'b0);
        check("burstlen_in_reset", 32'(mem_burstlen), 32'd32);
        check("burstlen1", 32'(burstlen1), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // Give every word a known value
        for (int i = 0; i < 1024; i++) wr(32'(i * 4), 32'h5000_0000 | 32'(i));

        // 1: basic burst from 0x100
        for (int i = 0; i < 32; i++) wr(32'h100 + 32'(4 * i), 32'hA5A5_0000 + 32'(i));
        do_read(32'h100, 1'b0, 32'h0, e0);
        check_end(e0);
        check("err_after_burst1", mem_err, 1'b0);

        // 2: wrap-around from word 1020
        for (int k = 0; k < 32; k++) begin
            int unsigned w;
            w = (1020 + k) % 1024;
            wr(32'(w * 4), 32'hC0DE_0000 | 32'(w));
        end
        do_read(32'hFF0, 1'b0, 32'h0, e0);
        check_end(e0);

        // 3: simultaneous write and read at 0x40
        do_read(32'h40, 1'b1, 32'hDEAD_BEEF, e0);
        check_end(e0);

        // 4: requests during a burst are ignored and flagged
        do_read(32'h0, 1'b0, 32'h0, e0);
        mem_addr = 32'h8; mem_in = 32'h1234_5678; mem_wrreq = 1'b1;
        @(negedge clk);
        mem_wrreq = 1'b0;
        check("err_set_by_wr", mem_err, 1'b1);
        mem_addr = 32'h300; mem_rdreq = 1'b1;
        @(negedge clk);
        mem_rdreq = 1'b0;
        check_end(e0);
        check("err_sticky", mem_err, 1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        check("err_cleared", mem_err, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // 5: back-to-back bursts
        do_read(32'h100, 1'b0, 32'h0, e0);
        wait_to_cycle(e0 + 34);
        check("b2b_final_valid", mem_out_valid, 1'b1);
        do_read(32'h200, 1'b0, 32'h0, e1);
        check("b2b_err", mem_err, 1'b0);
        check_end(e1);
        check("b2b_err_end", mem_err, 1'b0);

        // 6: reset after the 5th word aborts the burst
        do_read(32'h100, 1'b0, 32'h0, e0);
        cut = e0 + 7;
        wait_to_cycle(cut);
        reset_n = 1'b0;
        #1;
        while (exp_q.size() > 0 && exp_q[$].cyc > cut) void'(exp_q.pop_back());
        wait_to_cycle(cut + 1);
        check("abort_valid", mem_out_valid, 1'b0);
        check("abort_busy", mem_busy, 1'b0);
        check("abort_out", mem_out, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        do_read(32'h100, 1'b0, 32'h0, e0);
        check_end(e0);

        // READLATENCY=0, BURSTLEN=1 instance
        addr1 = 32'h14; in1 = 32'h0BAD_F00D; wrreq1 = 1'b1;
        @(negedge clk);
        wrreq1 = 1'b0; rdreq1 = 1'b1;
        @(negedge clk);
        rdreq1 = 1'b0;
        check("r0_busy", busy1, 1'b1);
        check("r0_valid_early", valid1, 1'b0);
        @(negedge clk);
        check("r0_valid", valid1, 1'b1);
        check("r0_data", out1, 32'h0BAD_F00D);
        check("r0_busy_last", busy1, 1'b0);
        @(negedge clk);
        check("r0_valid_after", valid1, 1'b0);
        check("r0_err", err1, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
